// File: rtl/uart_rx_byte_if.sv
// Signal bundle between the 8N1 receiver and its consumers: raw line in, byte/status out.
interface uart_rx_byte_if;
   logic       uart_rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (input uart_rxd, output rx_data, output rx_valid, output frame_err, output rx_busy);
   modport slave  (output uart_rxd, input rx_data, input rx_valid, input frame_err, input rx_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises RXD, samples at bit centre, pulses rx_valid or frame_err.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point, decision one clk later.
//
// state   | meaning
// S_IDLE  | line idle, waiting for rxd_s low
// S_START | timing to start-bit centre, rejects glitches
// S_DATA  | sampling 8 data bits LSB first
// S_STOP  | sampling stop bit
// S_BREAK | stop bit was low, waiting for line high
module uart_rx_byte #(
   parameter int CLK_FREQ_HZ = 200_000_000,
   parameter int BAUD_RATE   = 115_200
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_rx_byte_if.master   bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 8) begin : g_cpb_check
         $error("uart_rx_byte: CLKS_PER_BIT must be at least 8");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_sync1, r_sync2;
   logic             w_rxd_s;
   logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt, w_cnt_inc, w_cnt_after_start;
   logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic [7:0]       r_rx_data, w_rx_data_nxt;
   logic             r_rx_valid, w_rx_valid_nxt;
   logic             r_frame_err, w_frame_err_nxt;
   logic             w_at_point, w_samp_evt, w_samp_val;

   assign w_rxd_s = r_sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.uart_rxd;
         r_sync2 <= r_sync1;
      end
   end

   always_comb begin
      w_at_point = 1'b0;
      if (r_state == S_START)
         w_at_point = (r_clk_cnt == C_HALF);
      else if (r_state == S_DATA || r_state == S_STOP)
         w_at_point = (r_clk_cnt == C_LAST);
   end

   assign w_cnt_inc = (r_clk_cnt == C_LAST) ? '0 : r_clk_cnt + 1'b1;

`ifdef UART_RX_MAJORITY_EN
   // Vote uses rxd_s at point-1 (r_d2), point (r_d1) and point+1 (live); counter keeps free-running
   logic r_d1, r_d2, r_pend;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1   <= 1'b1;
         r_d2   <= 1'b1;
         r_pend <= 1'b0;
      end else begin
         r_d1   <= w_rxd_s;
         r_d2   <= r_d1;
         r_pend <= w_at_point;
      end
   end
   assign w_samp_evt        = r_pend;
   assign w_samp_val        = (r_d2 & r_d1) | (r_d2 & w_rxd_s) | (r_d1 & w_rxd_s);
   assign w_cnt_after_start = CNT_W'(1);
`else
   assign w_samp_evt        = w_at_point;
   assign w_samp_val        = w_rxd_s;
   assign w_cnt_after_start = '0;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_clk_cnt_nxt   = w_cnt_inc;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_rx_data_nxt   = r_rx_data;
      w_rx_valid_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clk_cnt_nxt = '0;
            if (!w_rxd_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_samp_evt) begin
               if (!w_samp_val) begin
                  w_state_nxt   = S_DATA;
                  w_clk_cnt_nxt = w_cnt_after_start;
                  w_bit_cnt_nxt = 3'd0;
               end else begin
                  w_state_nxt   = S_IDLE;
                  w_clk_cnt_nxt = '0;
               end
            end
         end
         S_DATA: begin
            if (w_samp_evt) begin
               w_shift_nxt = {w_samp_val, r_shift[7:1]};
               if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
               else                   w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
         end
         S_STOP: begin
            if (w_samp_evt) begin
               if (w_samp_val) begin
                  w_rx_data_nxt  = r_shift;
                  w_rx_valid_nxt = 1'b1;
                  w_state_nxt    = S_IDLE;
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            w_clk_cnt_nxt = '0;
            if (w_rxd_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_clk_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_clk_cnt   <= '0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_clk_cnt   <= w_clk_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.rx_busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed plus random 8N1 frames against a queue-based reference of expected pulses.
module tb_uart_rx_byte;
   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int CPB    = CLK_HZ / BAUD;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_byte_if bus ();

   uart_rx_byte #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // observed pulses: kind 0 = rx_valid, 1 = frame_err
   int         obs_kind[$];
   logic [7:0] obs_data[$];
   int         viol = 0;
   logic       prev_pulse = 1'b0;

   int         exp_kind[$];
   logic [7:0] exp_data[$];
   logic [7:0] model_last = 8'h00;

   always @(negedge clk) begin
      if (bus.rx_valid && bus.frame_err) viol++;
      if ((bus.rx_valid || bus.frame_err) && prev_pulse) viol++;
      if (bus.rx_valid) begin
         obs_kind.push_back(0);
         obs_data.push_back(bus.rx_data);
      end
      if (bus.frame_err) begin
         obs_kind.push_back(1);
         obs_data.push_back(bus.rx_data);
      end
      prev_pulse = bus.rx_valid || bus.frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.uart_rxd = 1'b1;
      end
   endtask

   // Drives bit times on negedges; cycle glitch_idx is forced high
   task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_idx, input int n_cycles);
      logic [9:0] frm;
      frm = {stop, d, 1'b0};
      for (int i = 0; i < n_cycles; i++) begin
         @(negedge clk);
         bus.uart_rxd = (i == glitch_idx) ? 1'b1 : frm[i / CPB];
      end
   endtask

   // Reference: a good stop delivers the byte, a low stop flags with the previous good byte
   task automatic expect_frame(input logic [7:0] d, input logic stop);
      if (stop) begin
         exp_kind.push_back(0);
         exp_data.push_back(d);
         model_last = d;
      end else begin
         exp_kind.push_back(1);
         exp_data.push_back(model_last);
      end
   endtask

   task automatic check_events(input string tag);
      int n;
      chk({tag, "_count"}, obs_kind.size(), exp_kind.size());
      n = (obs_kind.size() < exp_kind.size()) ? obs_kind.size() : exp_kind.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_kind%0d", tag, i), obs_kind[i], exp_kind[i]);
         chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
      end
      obs_kind.delete();
      obs_data.delete();
      exp_kind.delete();
      exp_data.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic       stop;
      int         gap;

      bus.uart_rxd = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rx_data", bus.rx_data, 8'h00);
      chk("rst_rx_valid", bus.rx_valid, 1'b0);
      chk("rst_frame_err", bus.frame_err, 1'b0);
      chk("rst_rx_busy", bus.rx_busy, 1'b0);
      rst_n = 1'b1;
      idle(5);

      // single frame
      send_frame(8'hF0, 1'b1, -1, 10 * CPB);
      expect_frame(8'hF0, 1'b1);
      idle(20);
      check_events("f0");
      chk("f0_rx_data", bus.rx_data, 8'hF0);

      // back-to-back frames
      send_frame(8'hF0, 1'b1, -1, 10 * CPB);
      send_frame(8'hE0, 1'b1, -1, 10 * CPB);
      send_frame(8'hD0, 1'b1, -1, 10 * CPB);
      expect_frame(8'hF0, 1'b1);
      expect_frame(8'hE0, 1'b1);
      expect_frame(8'hD0, 1'b1);
      idle(20);
      check_events("b2b");

      // short low glitch rejected
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.uart_rxd = 1'b0;
      end
      @(negedge clk);
      bus.uart_rxd = 1'b1;
      chk("glitch_busy_high", bus.rx_busy, 1'b1);
      idle(15);
      chk("glitch_busy_low", bus.rx_busy, 1'b0);
      check_events("glitch");

      // framing error followed by line break
      send_frame(8'h00, 1'b0, -1, 10 * CPB);
      expect_frame(8'h00, 1'b0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         bus.uart_rxd = 1'b0;
      end
      chk("brk_busy", bus.rx_busy, 1'b1);
      chk("brk_rx_data", bus.rx_data, model_last);
      check_events("ferr");
      idle(20);
      chk("brk_exit_busy", bus.rx_busy, 1'b0);
      send_frame(8'h5A, 1'b1, -1, 10 * CPB);
      expect_frame(8'h5A, 1'b1);
      idle(20);
      check_events("after_brk");

      // reset during bit 4
      send_frame(8'hA5, 1'b1, -1, 5 * CPB + 5);
      rst_n = 1'b0;
      bus.uart_rxd = 1'b1;
      @(negedge clk);
      chk("midrst_rx_data", bus.rx_data, 8'h00);
      chk("midrst_rx_valid", bus.rx_valid, 1'b0);
      chk("midrst_frame_err", bus.frame_err, 1'b0);
      chk("midrst_busy", bus.rx_busy, 1'b0);
      model_last = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(10);
      check_events("midrst");
      send_frame(8'h3C, 1'b1, -1, 10 * CPB);
      expect_frame(8'h3C, 1'b1);
      idle(20);
      check_events("after_rst");

      // one-cycle high glitch at the centre of bit 2
      send_frame(8'h00, 1'b1, 3 * CPB + CPB / 2, 10 * CPB);
`ifdef UART_RX_MAJORITY_EN
      expect_frame(8'h00, 1'b1);
`else
      expect_frame(8'h04, 1'b1);
`endif
      idle(20);
      check_events("centre_glitch");

      // random frames with random stop bit and inter-frame gaps
      for (int k = 0; k < 24; k++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, stop, -1, 10 * CPB);
         expect_frame(d, stop);
         gap = stop ? $urandom_range(0, 15) : 5 + $urandom_range(0, 15);
         idle(gap);
      end
      idle(25);
      check_events("rand");
      chk("rand_rx_data", bus.rx_data, model_last);
      chk("pulse_rules", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
